// File: rtl/wired_rob_ctrl.sv
// ROB pointer and commit sequencer: dual-slot allocation, in-order dual retire,
// and a cancel walk that drains every remaining entry after a flushing commit.
module wired_rob_ctrl #(
  parameter int ROB_LEN = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             p_req_i,
  output logic                   p_ready_o,
  output logic [1:0]             p_valid_o,
  output logic [2*ROB_LEN-1:0]   p_wrrid_o,
  output logic [2*ROB_LEN-1:0]   c_rrrid_o,
  input  logic [1:0]             c_rob_valid_i,
  input  logic [1:0]             c_flush_i,
  output logic [1:0]             c_retire_o,
  output logic                   c_cancel_o,
  output logic                   c_flush_done_o,
  output logic [ROB_LEN:0]       count_o
);

  typedef enum logic {NORMAL, WALK} state_t;

  localparam int                D        = 1 << ROB_LEN;
  localparam logic [ROB_LEN:0]  ALLOC_LIM = (ROB_LEN+1)'(D - 2);
  localparam logic [ROB_LEN:0]  ONE       = (ROB_LEN+1)'(1);
  localparam logic [ROB_LEN:0]  TWO       = (ROB_LEN+1)'(2);

  state_t               st_q;
  logic [ROB_LEN-1:0]   head_q, head1_q, tail_q, tail1_q;
  logic [ROB_LEN:0]     count_q;

  logic                 r0, r1, go_walk;
  logic [1:0]           alloc_n, ret_n;

  // Allocation needs room for a full pair, so one free slot is never granted.
  assign p_ready_o = (st_q == NORMAL) && (count_q <= ALLOC_LIM);
  assign p_valid_o = p_req_i & {2{p_ready_o}};

  assign p_wrrid_o = {tail1_q, tail_q};
  assign c_rrrid_o = {head1_q, head_q};
  assign count_o   = count_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    r0             = 1'b0;
    r1             = 1'b0;
    go_walk        = 1'b0;
    c_retire_o     = 2'b00;
    c_cancel_o     = 1'b0;
    c_flush_done_o = 1'b0;
    if (st_q == NORMAL) begin
      r0         = (count_q >= ONE) & c_rob_valid_i[0];
      r1         = r0 & ~c_flush_i[0] & (count_q >= TWO) & c_rob_valid_i[1];
      c_retire_o = {r1, r0};
      go_walk    = (r0 & c_flush_i[0]) | (r1 & c_flush_i[1]);
    end else begin
      // Walk drains regardless of result/flush flags; done when this is the last pair.
      c_cancel_o     = 1'b1;
      c_flush_done_o = (count_q <= TWO);
      if (count_q >= TWO)      c_retire_o = 2'b11;
      else if (count_q == ONE) c_retire_o = 2'b01;
    end
  end

  assign alloc_n = {1'b0, p_valid_o[1]} + {1'b0, p_valid_o[0]};
  assign ret_n   = {1'b0, c_retire_o[1]} + {1'b0, c_retire_o[0]};

  // NOTE: reset is sampled synchronously, and state updates use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= NORMAL;
      head_q  <= '0;
      head1_q <= ROB_LEN'(1);
      tail_q  <= '0;
      tail1_q <= ROB_LEN'(1);
      count_q <= '0;
    end else begin
      head_q  <= head_q + ROB_LEN'(ret_n);
      head1_q <= head_q + ROB_LEN'(ret_n) + ROB_LEN'(1);
      tail_q  <= tail_q + ROB_LEN'(alloc_n);
      tail1_q <= tail_q + ROB_LEN'(alloc_n) + ROB_LEN'(1);
      count_q <= count_q + (ROB_LEN+1)'(alloc_n) - (ROB_LEN+1)'(ret_n);
      case (st_q)
        NORMAL:  if (go_walk) st_q <= WALK;
        WALK:    if (count_q <= TWO) st_q <= NORMAL;
        default: st_q <= NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_wired_rob_ctrl.sv
// Self-checking bench for wired_rob_ctrl: directed scenarios plus random traffic,
// compared against a queue-of-ids model of ROB occupancy.
module tb_wired_rob_ctrl;

  localparam int RL = 6;
  localparam int D  = 1 << RL;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      p_req_i = '0;
  logic            p_ready_o;
  logic [1:0]      p_valid_o;
  logic [2*RL-1:0] p_wrrid_o;
  logic [2*RL-1:0] c_rrrid_o;
  logic [1:0]      c_rob_valid_i = '0;
  logic [1:0]      c_flush_i = '0;
  logic [1:0]      c_retire_o;
  logic            c_cancel_o;
  logic            c_flush_done_o;
  logic [RL:0]     count_o;

  wired_rob_ctrl #(.ROB_LEN(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_req_i(p_req_i), .p_ready_o(p_ready_o), .p_valid_o(p_valid_o),
    .p_wrrid_o(p_wrrid_o), .c_rrrid_o(c_rrrid_o),
    .c_rob_valid_i(c_rob_valid_i), .c_flush_i(c_flush_i),
    .c_retire_o(c_retire_o), .c_cancel_o(c_cancel_o),
    .c_flush_done_o(c_flush_done_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: ids currently in the ROB, oldest first; next id to hand out; walk flag.
  int q[$];
  int tail_m = 0;
  bit walk_m = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic guard_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: loop bound expired, observed count %0d", tag, count_o);
  endtask

  // One cycle: drive at negedge, check outputs 1ns later, then advance the model.
  task automatic step(input logic [1:0] req, input logic [1:0] rv,
                      input logic [1:0] fl, input bit rst = 1'b1);
    int cnt, head, nret;
    bit ready, r0, r1, go, cancel, done;
    logic [1:0] val, ret;
    logic [2*RL-1:0] ewr, err;
    @(negedge clk);
    rst_n = rst; p_req_i = req; c_rob_valid_i = rv; c_flush_i = fl;
    #1;
    cnt   = q.size();
    head  = (cnt != 0) ? q[0] : tail_m;
    ready = !walk_m && (D - cnt >= 2);
    val   = req & {2{ready}};
    go = 1'b0; cancel = 1'b0; done = 1'b0;
    if (!walk_m) begin
      r0   = (cnt >= 1) && rv[0];
      r1   = r0 && !fl[0] && (cnt >= 2) && rv[1];
      ret  = {r1, r0};
      nret = int'(r0) + int'(r1);
      go   = (r0 && fl[0]) || (r1 && fl[1]);
    end else begin
      nret   = (cnt < 2) ? cnt : 2;
      ret    = (nret == 2) ? 2'b11 : (nret == 1) ? 2'b01 : 2'b00;
      cancel = 1'b1;
      done   = (cnt <= 2);
    end
    ewr = {RL'((tail_m + 1) % D), RL'(tail_m)};
    err = {RL'((head + 1) % D), RL'(head)};
    check("p_ready",   16'(p_ready_o),      16'(ready));
    check("p_valid",   16'(p_valid_o),      16'(val));
    check("p_wrrid",   16'(p_wrrid_o),      16'(ewr));
    check("c_rrrid",   16'(c_rrrid_o),      16'(err));
    check("c_retire",  16'(c_retire_o),     16'(ret));
    check("c_cancel",  16'(c_cancel_o),     16'(cancel));
    check("flush_done",16'(c_flush_done_o), 16'(done));
    check("count",     16'(count_o),        16'(cnt));
    if (!rst) begin
      q.delete(); tail_m = 0; walk_m = 1'b0;
    end else begin
      repeat (nret) void'(q.pop_front());
      for (int i = 0; i < 2; i++)
        if (val[i]) begin q.push_back(tail_m); tail_m = (tail_m + 1) % D; end
      if (!walk_m) walk_m = go;
      else if (cnt <= 2) walk_m = 1'b0;
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((q.size() != 0 || walk_m) && g < 200) begin step(2'b00, 2'b11, 2'b00); g++; end
    if (g >= 200) guard_fail("drain");
  endtask

  task automatic fill7();
    step(2'b11, 2'b00, 2'b00); step(2'b11, 2'b00, 2'b00);
    step(2'b11, 2'b00, 2'b00); step(2'b01, 2'b00, 2'b00);
  endtask

  initial begin
    int g;
    logic [1:0] rq;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    // Reset values and dual allocation with no results ready.
    step(2'b11, 2'b00, 2'b00);
    step(2'b11, 2'b00, 2'b00);
    step(2'b11, 2'b00, 2'b00);
    // In-order: slot 1 ready alone cannot retire; then both retire.
    step(2'b00, 2'b10, 2'b00);
    step(2'b00, 2'b11, 2'b00);
    step(2'b00, 2'b00, 2'b00);

    // Full boundary: fill to 63, retire 2 while allocation is refused.
    g = 0;
    while (q.size() < D - 2 && g < 100) begin step(2'b11, 2'b00, 2'b00); g++; end
    if (g >= 100) guard_fail("fill");
    step(2'b01, 2'b00, 2'b00);
    step(2'b11, 2'b11, 2'b00);
    step(2'b00, 2'b00, 2'b00);

    // Wrap-around: empty ROB with head = tail = 63.
    g = 0;
    while ((tail_m != D - 1 || q.size() != 0) && g < 500) begin
      step((tail_m != D - 1) ? 2'b01 : 2'b00, 2'b11, 2'b00); g++;
    end
    if (g >= 500) guard_fail("wrap_setup");
    step(2'b11, 2'b00, 2'b00);
    step(2'b00, 2'b00, 2'b00);
    drain();

    // Flush walk from count 7.
    fill7();
    step(2'b00, 2'b01, 2'b01);
    for (int i = 0; i < 3; i++) step(2'b11, 2'($urandom), 2'($urandom));
    step(2'b00, 2'b00, 2'b00);

    // Flushing commit of the last entry: single empty walk cycle.
    step(2'b01, 2'b00, 2'b00);
    step(2'b00, 2'b01, 2'b01);
    step(2'b11, 2'b11, 2'b11);
    step(2'b00, 2'b00, 2'b00);

    // Slot-1 flush on a dual retire, then reset in the middle of the walk.
    fill7();
    step(2'b00, 2'b11, 2'b10);
    step(2'b00, 2'b00, 2'b00);
    step(2'b00, 2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 2'b00);
    step(2'b11, 2'b00, 2'b00);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 2))
        0:       rq = 2'b00;
        1:       rq = 2'b01;
        default: rq = 2'b11;
      endcase
      step(rq, 2'($urandom), ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00,
           ($urandom_range(0, 99) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wired_rob_ctrl.md
# wired_rob_ctrl

Pointer and commit sequencer for the ROB storage array. It allocates ROB ids to the dispatch (P) stage two at a time and drives the ROB commit-read addresses. It decides in-order retirement of up to two entries per cycle. On a flushing commit it walks every remaining entry out through the commit port as cancelled, so the rename table is restored. The block sits between dispatch, the ROB storage and the commit/rename logic.

## Interface
Parameters:
- `ROB_LEN`, default `6`: log2 of ROB depth. Depth `D = 1 << ROB_LEN`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `p_req_i` in 2: dispatch allocation requests. Bit 1 is set only when bit 0 is set.
- `p_ready_o` out 1: allocation is accepted this cycle.
- `p_valid_o` out 2: granted allocations, equal to `p_req_i & {2{p_ready_o}}`. Drives the ROB write enables.
- `p_wrrid_o` out 2×ROB_LEN: ids for the slots, `{tail+1, tail}`.
- `c_rrrid_o` out 2×ROB_LEN: commit read ids, `{head+1, head}`.
- `c_rob_valid_i` in 2: result-valid flags returned by the ROB for `c_rrrid_o`.
- `c_flush_i` in 2: the entry at that slot needs a pipeline flush (exception, mispredict, uncached, SC fail).
- `c_retire_o` out 2: retire strobes. Bit 1 is set only when bit 0 is set.
- `c_cancel_o` out 1: the retiring entries this cycle are cancelled (walk). The consumer undoes rename only.
- `c_flush_done_o` out 1: one-cycle pulse when the walk completes.
- `count_o` out ROB_LEN+1: current occupancy.

## Operation
- Registers:
  - `head_q` and `tail_q`, each ROB_LEN bits, wrapping modulo D.
  - `count_q`, ROB_LEN+1 bits, range 0..D.
  - State `st_q` in {NORMAL, WALK}.
- `p_ready_o = (st_q == NORMAL) && (D - count_q >= 2)`. The ready check is independent of `p_req_i`.
- Allocation count `a = popcount(p_valid_o)`. `tail_q` advances by `a`.
- In NORMAL, with `c_cancel_o = 0`:
  - `r0 = (count_q >= 1) & c_rob_valid_i[0]`.
  - `r1 = r0 & ~c_flush_i[0] & (count_q >= 2) & c_rob_valid_i[1]`.
  - `c_retire_o = {r1, r0}`.
  - If `(r0 & c_flush_i[0]) | (r1 & c_flush_i[1])`, the next state is WALK.
  - `c_flush_i` on a non-retiring slot is ignored.
- In WALK, with `c_cancel_o = 1`:
  - `c_retire_o` retires `min(count_q, 2)` entries, ignoring `c_rob_valid_i` and `c_flush_i`.
  - When `count_q <= 2`: assert `c_flush_done_o` and return to NORMAL next cycle.
  - `p_valid_o = 0` throughout WALK.
- Retire count `r = popcount(c_retire_o)`. `head_q` advances by `r`.
- `count_q <= count_q + a - r`, computed at width ROB_LEN+1. It never overflows past D or underflows below 0.
- A flushing commit with count after retire equal to 0 still takes one WALK cycle: no retire, `c_flush_done_o = 1`.
- Tail wraps from D-1 to 0 with no special case. Slot 1 id `head+1` / `tail+1` wraps the same way.

## Timing
- Reset values (cycle after `rst_n` low at a clk edge):
  - `head_q = tail_q = 0`, `count_q = 0`, `st_q = NORMAL`.
  - `p_ready_o = 1`, `p_valid_o = 0` (no requests pending).
  - `p_wrrid_o = {1,0}`, `c_rrrid_o = {1,0}`.
  - `c_retire_o = 0`, `c_cancel_o = 0`, `c_flush_done_o = 0`, `count_o = 0`.
- Reset asserted mid-WALK abandons the walk. No `c_flush_done_o` is produced.
- `c_rrrid_o` and `p_wrrid_o` are register outputs.
- `p_ready_o`, `p_valid_o`, `c_retire_o`, `c_cancel_o` and `c_flush_done_o` are combinational from registers plus same-cycle inputs.
- ROB read is same-cycle (`c_rob_valid_i` responds combinationally to `c_rrrid_o`).
- Allocation and retirement in the same cycle are both applied.
- A freed slot is reallocatable from the next cycle, never the same cycle. `p_ready_o` uses `count_q` only.
- An entry allocated at cycle t is retirable at t+1 at the earliest, given `c_rob_valid_i`.
- WALK length is `ceil(count_after_flush / 2)` cycles, minimum 1. NORMAL resumes the cycle after `c_flush_done_o`.

## Test plan
- **Reset / dual allocate:** after reset, `p_req_i = 2'b11` for 3 cycles. Expect:
  - `p_wrrid_o` = {1,0}, {3,2}, {5,4}.
  - `count_o` = 6.
  - `c_retire_o = 0` while `c_rob_valid_i = 0`.
- **In-order dual retire:** with count 6 and `c_rob_valid_i = 2'b10`, expect `c_retire_o = 0`. Then set `2'b11` and expect `c_retire_o = 2'b11`, `c_rrrid_o` advances to {3,2}, `count_o = 4`.
- **Full boundary, D = 64:** fill to 63. Expect `p_ready_o = 0`. In the same cycle, retire 2 and request 2: allocation is refused, and the next cycle count = 61 and `p_ready_o = 1`.
- **Wrap-around:** drive head = tail = 63, count 0, `p_req_i = 2'b11`. Expect `p_wrrid_o = {0,63}`. Next `c_rrrid_o = {0,63}`, and `tail_q = 1`.
- **Flush walk:** with count 7, slot 0 valid with `c_flush_i = 2'b01`. Expect:
  - `c_retire_o = 2'b01` with `c_cancel_o = 0`.
  - Then 3 WALK cycles retiring 2, 2, 2 with `c_cancel_o = 1`. `c_flush_done_o` pulses on the third.
  - `p_valid_o = 0` throughout, and `count_o` ends at 0.
- **Flush as last entry / reset mid-walk:** count 1, flush commit. Expect one WALK cycle with `c_retire_o = 0` and `c_flush_done_o = 1`. Separately, `rst_n = 0` during WALK must give all reset values next cycle.
